// File: rtl/tick_divider_pkg.sv
// -----------------------------------------------------------------------------
// tick_divider_pkg
//   Shared constants and types for the tick_divider clock-enable generator.
//   - CNT_W_DEFAULT : default counter/divisor width (26 bits covers 1 s @ 25 MHz)
//   - DIV_1S_25MHZ  : divisor for a 1 s period at 25 MHz
//   - DIV_1MS_25MHZ : divisor for a 1 ms period at 25 MHz
//   - div_t         : divisor type at the default width
// -----------------------------------------------------------------------------
package tick_divider_pkg;

    localparam int CNT_W_DEFAULT = 26;
    localparam int DIV_1S_25MHZ  = 25_000_000;
    localparam int DIV_1MS_25MHZ = 25_000;

    typedef logic [CNT_W_DEFAULT-1:0] div_t;

endpackage

// File: rtl/tick_divider_ch.sv
// -----------------------------------------------------------------------------
// tick_divider_ch
//   One channel of the tick divider: a programmable divisor register, a
//   free-running counter, a one-cycle tick strobe and (optionally) a 50%-duty
//   square output that toggles on every tick.
//
//   Build option: TICK_DIVIDER_SQ_EN
//     defined     -> sq toggle flop is implemented
//     not defined -> sq is tied to 0; tick behaviour is unchanged
//
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  synchronous active-high reset, overrides everything
//   en       in  count enable for this channel
//   sync     in  restart this channel's phase (div kept)
//   load     in  load load_div into div and restart phase
//   load_div in  new divisor (0 behaves as 1)
//   tick     out one-cycle strobe at each terminal count (registered)
//   sq       out square wave, toggles on each tick (registered)
// -----------------------------------------------------------------------------
module tick_divider_ch #(
    parameter int               CNT_W       = 26,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             tick,
    output logic             sq
);

    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;     // terminal count = max(div,1) - 1
    logic             restart;
    logic             term;

    // A stored divisor of 0 behaves as 1, so its terminal count is 0.
    assign last    = (div == '0) ? '0 : div - CNT_W'(1);
    assign restart = load | sync;
    // >= rather than == so a counter that is somehow past the terminal value
    // still wraps instead of running the full CNT_W range.
    assign term    = en & (cnt >= last);

    always_ff @(posedge clk) begin
        if (rst) begin
            div  <= DEFAULT_DIV;
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            if (load) begin
                div <= load_div;
            end
            // Restart wins over a coincident terminal count: no tick escapes.
            if (restart) begin
                cnt  <= '0;
                tick <= 1'b0;
            end else if (en) begin
                tick <= term;
                cnt  <= term ? '0 : cnt + CNT_W'(1);
            end else begin
                tick <= 1'b0;
            end
        end
    end

`ifdef TICK_DIVIDER_SQ_EN
    logic sq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_q <= 1'b0;
        end else if (restart) begin
            sq_q <= 1'b0;
        end else if (term) begin
            sq_q <= ~sq_q;
        end
    end

    assign sq = sq_q;
`else
    assign sq = 1'b0;
`endif

endmodule

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
//   Multi-channel run-time-programmable clock-enable generator. Produces
//   NUM_CH independent one-cycle tick strobes (and optional square outputs)
//   from the single system clock. No derived clocks are generated; consumers
//   use tick as a clock enable.
//
//   Build option: TICK_DIVIDER_SQ_EN (square outputs; sq = 0 when undefined)
//
// Parameters:
//   NUM_CH      number of channels (1..16)
//   CNT_W       counter/divisor width
//   DEFAULT_DIV divisor loaded into every channel at reset
//
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   en       in  [NUM_CH]   per-channel count enable
//   sync     in  restart all channels in phase
//   load     in  write load_div into channel load_ch
//   load_ch  in  [LCH_W]    target channel (values >= NUM_CH ignored)
//   load_div in  [CNT_W]    new divisor
//   tick     out [NUM_CH]   one-cycle strobe per channel period
//   sq       out [NUM_CH]   square wave, period 2*div cycles
// -----------------------------------------------------------------------------
module tick_divider
    import tick_divider_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter int                CNT_W       = CNT_W_DEFAULT,
    parameter longint unsigned   DEFAULT_DIV = DIV_1S_25MHZ,
    localparam int               LCH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              load,
    input  logic [LCH_W-1:0]  load_ch,
    input  logic [CNT_W-1:0]  load_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq
);

    // Elaboration-time sanity checks on the configuration.
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("tick_divider: NUM_CH must be 1..16");
    end
    if (CNT_W < 64 && DEFAULT_DIV >= (64'd1 << CNT_W)) begin : g_bad_default
        $error("tick_divider: DEFAULT_DIV does not fit in CNT_W bits");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic load_hit;

        // Only an exact channel match loads; codes >= NUM_CH match nothing.
        assign load_hit = load && (load_ch == LCH_W'(i));

        tick_divider_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (CNT_W'(DEFAULT_DIV))
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .sync     (sync),
            .load     (load_hit),
            .load_div (load_div),
            .tick     (tick[i]),
            .sq       (sq[i])
        );
    end

endmodule

// File: tb/tb_tick_divider.sv
// -----------------------------------------------------------------------------
// tb_tick_divider
//   Self-checking bench for tick_divider. A behavioural model tracks, per
//   channel, the number of enabled cycles since the last restart; a tick is
//   expected whenever that count is a multiple of max(div,1), and sq is the
//   parity of ticks since restart (0 when TICK_DIVIDER_SQ_EN is undefined).
// -----------------------------------------------------------------------------
module tb_tick_divider;

    localparam int              NUM_CH = 4;
    localparam int              CNT_W  = 26;
    localparam longint unsigned DEF    = 25_000_000;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              load;
    logic [1:0]        load_ch;
    logic [CNT_W-1:0]  load_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;

    always #20 clk = ~clk;

    tick_divider #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .load     (load),
        .load_ch  (load_ch),
        .load_div (load_div),
        .tick     (tick),
        .sq       (sq)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state
    longint            m_div [NUM_CH];
    longint            m_n   [NUM_CH];
    logic [NUM_CH-1:0] m_tick;
    logic [NUM_CH-1:0] m_sq;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NUM_CH-1:0] exp_sq();
`ifdef TICK_DIVIDER_SQ_EN
        return m_sq;
`else
        return '0;
`endif
    endfunction

    function automatic logic sq_bit(input logic b);
`ifdef TICK_DIVIDER_SQ_EN
        return b;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            longint d;
            d = (m_div[c] == 0) ? 1 : m_div[c];
            if (rst) begin
                m_div[c]  = longint'(DEF);
                m_n[c]    = 0;
                m_tick[c] = 1'b0;
                m_sq[c]   = 1'b0;
            end else if (sync || (load && int'(load_ch) == c)) begin
                if (load && int'(load_ch) == c) m_div[c] = longint'(load_div);
                m_n[c]    = 0;
                m_tick[c] = 1'b0;
                m_sq[c]   = 1'b0;
            end else if (en[c]) begin
                m_n[c]++;
                m_tick[c] = (m_n[c] % d == 0);
                if (m_tick[c]) m_sq[c] = ~m_sq[c];
            end else begin
                m_tick[c] = 1'b0;
            end
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model_tick", tick, m_tick);
        chk("model_sq", sq, exp_sq());
    endtask

    task automatic do_load(input int ch, input int d);
        load     = 1'b1;
        load_ch  = 2'(ch);
        load_div = CNT_W'(d);
        cycle();
        load     = 1'b0;
    endtask

    typedef struct {
        logic [NUM_CH-1:0] en;
        logic              load;
        logic [CNT_W-1:0]  div;
        logic              exp_t;
        logic              exp_s;
    } vec_t;

    vec_t tbl [16];
    localparam logic [15:0] T_PAT = 16'b1000_0100_0010_0000;
    localparam logic [15:0] S_PAT = 16'b1000_0011_1110_0000;

    initial begin
        int k;

        for (int c = 0; c < NUM_CH; c++) begin
            m_div[c] = 0;
            m_n[c]   = 0;
        end
        m_tick = '0;
        m_sq   = '0;

        tbl[0] = '{4'b0001, 1'b1, CNT_W'(5), 1'b0, 1'b0};
        for (int r = 1; r < 16; r++)
            tbl[r] = '{4'b0001, 1'b0, '0, T_PAT[r], S_PAT[r]};

        // Reset overrides load and enables
        rst = 1'b1; en = '1; sync = 1'b0;
        load = 1'b1; load_ch = 2'd0; load_div = CNT_W'(7);
        repeat (3) cycle();
        chk("reset_tick", tick, 0);
        chk("reset_sq", sq, 0);
        chk("reset_div0", dut.g_ch[0].u_ch.div, DEF);
        rst = 1'b0; load = 1'b0; en = '0;

        // Table: divisor 5 on ch0
        for (int r = 0; r < 16; r++) begin
            en = tbl[r].en; load = tbl[r].load; load_ch = 2'd0; load_div = tbl[r].div;
            cycle();
            chk("tbl_tick0", tick[0], tbl[r].exp_t);
            chk("tbl_sq0", sq[0], sq_bit(tbl[r].exp_s));
        end
        load = 1'b0;

        // Divisor 0 and 1 tick every cycle
        en = 4'b0110;
        do_load(1, 0);
        do_load(2, 1);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("div0_tick1", tick[1], 1);
            chk("div1_tick2", tick[2], 1);
        end

        // Enable stall delays next tick by exactly the stall length
        en = 4'b0001;
        do_load(0, 4);
        repeat (2) cycle();
        en[0] = 1'b0;
        repeat (3) cycle();
        chk("stall_cnt_hold", dut.g_ch[0].u_ch.cnt, 2);
        en[0] = 1'b1;
        k = 5;
        do begin
            cycle();
            k++;
        end while (tick[0] !== 1'b1 && k < 25);
        chk("stall_tick_edge", k, 7);

        // Sync restarts channels in phase
        en = 4'b1111;
        do_load(0, 4);
        do_load(3, 6);
        repeat ($urandom_range(1, 7)) cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            chk("sync_tick0", tick[0], (i % 4 == 0));
            chk("sync_tick3", tick[3], (i % 6 == 0));
        end

        // Load at terminal count suppresses the tick
        en = 4'b0001;
        do_load(0, 5);
        repeat (4) cycle();
        do_load(0, 3);
        chk("tc_load_notick", tick[0], 0);
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk("tc_load_next", tick[0], (i == 3));
        end
        cycle();
        rst = 1'b1;
        cycle();
        chk("midrst_tick", tick, 0);
        chk("midrst_sq", sq, 0);
        chk("midrst_div0", dut.g_ch[0].u_ch.div, DEF);
        rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            rst      = ($urandom_range(0, 149) == 0);
            en       = NUM_CH'($urandom | $urandom);
            sync     = ($urandom_range(0, 29) == 0);
            load     = ($urandom_range(0, 6) == 0);
            load_ch  = 2'($urandom_range(0, 3));
            load_div = CNT_W'($urandom_range(0, 9));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_divider.md
# tick_divider

Multi-channel, run-time-programmable clock-enable generator that replaces the fixed one-second divider in the NinjaReflex timing path. From the single 25 MHz system clock it produces NUM_CH independent one-cycle `tick` strobes and optional 50%-duty square outputs. The game FSM, LED blink and reaction-time scoring logic consume these strobes as clock enables. No derived clocks are generated.

## Interface
Parameters:
- NUM_CH, 4, number of independent channels (1..16)
- CNT_W, 26, counter/divisor width in bits
- DEFAULT_DIV, 25_000_000, divisor loaded into every channel at reset (1 s at 25 MHz)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  NUM_CH  per-channel count enable
- sync  in  1  restart all channels in phase
- load  in  1  write `load_div` into channel `load_ch`
- load_ch  in  $clog2(NUM_CH) (min 1)  target channel of `load`
- load_div  in  CNT_W  new divisor
- tick  out  NUM_CH  one-cycle strobe per channel period
- sq  out  NUM_CH  square wave, period 2·div cycles

## Operation
- Each channel holds a divisor register `div` and a counter `cnt`, both CNT_W bits wide.
- Reset (`rst`=1): `div`=DEFAULT_DIV, `cnt`=0, `tick`=0, `sq`=0 on all channels. `rst` overrides every other input.
- Effective divisor is `max(div,1)`. A `load_div` of 0 is stored but behaves as 1.
- Counting (en[i]=1, no sync, no load to channel i):
  - if `cnt` ≥ effective div−1: `cnt`←0, `tick`←1, `sq`←~`sq`
  - else: `cnt`←`cnt`+1, `tick`←0
- Comparing with ≥ guarantees wrap even if `cnt` is out of range.
- en[i]=0: `cnt` and `sq` hold, `tick`←0.
- load (channel `load_ch` only): `div`←`load_div`, `cnt`←0, `sq`←0, `tick`←0.
  - Takes priority over that channel's terminal count in the same cycle, so no tick is emitted.
  - `load_ch` ≥ NUM_CH is ignored.
- sync: every channel gets `cnt`←0, `sq`←0, `tick`←0; `div` is unchanged.
  - sync and load in the same cycle: both apply.
- Arithmetic is unsigned. DEFAULT_DIV and `load_div` must fit in CNT_W bits (elaboration assertion on DEFAULT_DIV).

## Timing
- Outputs are fully registered, with no combinational input-to-output path.
- With rst released before edge 1 and en=1 throughout, a channel with divisor D raises `tick` after edge D, 2D, 3D, …, each time for exactly one cycle.
- Effective D=1: `tick` is constantly 1 and `sq` toggles every cycle.
- Load/sync latency: the new phase starts at the edge that samples them. The first tick follows D edges later.
- A disabled cycle delays the next tick by exactly one cycle.

## Configuration
- TICK_DIVIDER_SQ_EN defined: `sq` toggle flops are implemented as described.
- Not defined: `sq` is tied to 0, and the toggle flops and their load/sync clearing are removed. `tick` behaviour is identical in both builds.

## Structure
- Package `tick_divider_pkg` holds:
  - `CNT_W_DEFAULT`, `DIV_1S_25MHZ` (25_000_000), `DIV_1MS_25MHZ` (25_000)
  - typedef `div_t` (logic [CNT_W_DEFAULT-1:0])
- Sub-module `tick_divider_ch` implements one channel (`div`, `cnt`, `tick`, `sq` and per-channel load/sync handling). The top instantiates it NUM_CH times in a generate loop and decodes `load_ch`.

## Test plan
- Reset: hold rst 3 cycles with en=all-1 and load=1 → tick=0, sq=0, and ch0 div reads DEFAULT_DIV (probe).
- Load ch0 div=5, en[0]=1 → tick[0] high after edges 5, 10, 15 after the load; sq[0] toggles at the same edges (period 10).
- Load ch1 div=0 and ch2 div=1 → tick[1] and tick[2] continuously 1; sq toggles every cycle.
- ch0 div=4, drop en[0] for 3 cycles mid-count → next tick delayed by exactly 3 cycles; cnt holds.
- ch0 div=4, ch3 div=6, assert sync at an arbitrary cycle → both restart: ticks 4 and 6 edges later; ticks coincide every 12.
- ch0 div=5: load div=3 in the terminal-count cycle → no tick that cycle, next tick 3 edges later. Then assert rst mid-count → all outputs 0 next cycle.
